// File: rtl/game_clock_countdown.sv
// MM:SS countdown game clock: loads a clamped BCD value, decrements once per
// prescaled second, pulses `expired` at 00:00 and draws its digits on the pixel stream.

module char_display (
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic [10:0] x_pos,
    input  logic [9:0]  y_pos,
    input  logic [8:0]  rom_base_addr,
    output logic        pixel_on
);
    logic [10:0] dx;
    logic [9:0]  dy;
    logic        in_box;
    logic [8:0]  rom_addr;
    logic [7:0]  row_bits;

    // Each glyph is 8 rows of 8 bits packed MSB-first, MSB is the leftmost pixel.
    function automatic logic [7:0] font_row(input logic [8:0] addr);
        logic [63:0] glyph;
        logic [5:0]  shift;
        glyph = 64'h0;
        if (addr[8:7] == 2'b11) begin
            case (addr[6:3])
                4'd0:    glyph = 64'h3C666E7666663C00;
                4'd1:    glyph = 64'h183818181818_7E00;
                4'd2:    glyph = 64'h3C66060C30607E00;
                4'd3:    glyph = 64'h3C66061C06663C00;
                4'd4:    glyph = 64'h0C1C3C6C7E0C0C00;
                4'd5:    glyph = 64'h7E607C0606663C00;
                4'd6:    glyph = 64'h3C60607C66663C00;
                4'd7:    glyph = 64'h7E060C1818181800;
                4'd8:    glyph = 64'h3C66663C66663C00;
                4'd9:    glyph = 64'h3C66663E060C3800;
                default: glyph = 64'h0;
            endcase
        end
        shift = {3'd7 - addr[2:0], 3'b000};
        return 8'(glyph >> shift);
    endfunction

    always_comb begin
        dx       = x - x_pos;
        dy       = y - y_pos;
        in_box   = (x >= x_pos) && (dx < 11'd8) && (y >= y_pos) && (dy < 10'd8);
        rom_addr = rom_base_addr + {6'd0, dy[2:0]};
        row_bits = font_row(rom_addr);
        pixel_on = in_box && row_bits[3'd7 - dx[2:0]];
    end
endmodule

module game_clock_countdown #(
    parameter logic [26:0] CLKS_PER_SEC = 27'd65000000,
    parameter logic [10:0] X_BOX        = 11'd0,
    parameter logic [9:0]  Y_BOX        = 10'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        pause,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    output logic [15:0] digits,
    output logic        running,
    output logic        expired,
    output logic        pixel_on,
    output logic [1:0]  fsm_state
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUNNING = 2'd1;
    localparam logic [1:0] PAUSED  = 2'd2;
    localparam logic [1:0] EXPIRED = 2'd3;

    logic [1:0]  state, state_n;
    logic [26:0] presc, presc_n;
    logic [15:0] digits_n, dec_value;
    logic        tick;

    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = v;
        if (m1 > 4'd9) m1 = 4'd9;
        if (m0 > 4'd9) m0 = 4'd9;
        if (s1 > 4'd5) s1 = 4'd5;
        if (s0 > 4'd9) s0 = 4'd9;
        return {m1, m0, s1, s0};
    endfunction

    // Borrow ripples S0 -> S1 -> M0 -> M1; 0000 is a fixed point.
    function automatic logic [15:0] dec_bcd(input logic [15:0] v);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = v;
        if (v != 16'h0000) begin
            if (s0 != 4'd0) s0 = s0 - 4'd1;
            else begin
                s0 = 4'd9;
                if (s1 != 4'd0) s1 = s1 - 4'd1;
                else begin
                    s1 = 4'd5;
                    if (m0 != 4'd0) m0 = m0 - 4'd1;
                    else begin
                        m0 = 4'd9;
                        m1 = m1 - 4'd1;
                    end
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    assign dec_value = dec_bcd(digits);

    always_comb begin
        state_n  = state;
        presc_n  = presc;
        digits_n = digits;
        tick     = 1'b0;
        if (load) begin
            state_n  = IDLE;
            presc_n  = 27'd0;
            digits_n = clamp_bcd(load_value);
        end else begin
            case (state)
                IDLE: begin
                    if (start && digits != 16'h0000) begin
                        state_n = RUNNING;
                        presc_n = 27'd0;
                    end
                end
                RUNNING: begin
                    if (presc == CLKS_PER_SEC - 27'd1) begin
                        presc_n = 27'd0;
                        tick    = 1'b1;
                    end else begin
                        presc_n = presc + 27'd1;
                    end
                    if (tick) digits_n = dec_value;
                    // Expiry outranks a coincident pause.
                    if (tick && dec_value == 16'h0000) state_n = EXPIRED;
                    else if (pause)                    state_n = PAUSED;
                end
                PAUSED: begin
                    if (start && !pause) state_n = RUNNING;
                end
                EXPIRED: ;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            presc   <= 27'd0;
            digits  <= 16'h0000;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_n;
            presc   <= presc_n;
            digits  <= digits_n;
            running <= (state_n == RUNNING);
            expired <= (state_n == EXPIRED) && (state != EXPIRED);
        end
    end

    assign fsm_state = state;

    logic [3:0] pix;

    char_display u_m1 (
        .x(x), .y(y), .x_pos(X_BOX + 11'd0), .y_pos(Y_BOX),
        .rom_base_addr({2'b00, digits[15:12], 3'b000} + 9'h180), .pixel_on(pix[3])
    );
    char_display u_m0 (
        .x(x), .y(y), .x_pos(X_BOX + 11'd8), .y_pos(Y_BOX),
        .rom_base_addr({2'b00, digits[11:8], 3'b000} + 9'h180), .pixel_on(pix[2])
    );
    // Columns +16..+23 are left dark for an externally drawn colon.
    char_display u_s1 (
        .x(x), .y(y), .x_pos(X_BOX + 11'd24), .y_pos(Y_BOX),
        .rom_base_addr({2'b00, digits[7:4], 3'b000} + 9'h180), .pixel_on(pix[1])
    );
    char_display u_s0 (
        .x(x), .y(y), .x_pos(X_BOX + 11'd32), .y_pos(Y_BOX),
        .rom_base_addr({2'b00, digits[3:0], 3'b000} + 9'h180), .pixel_on(pix[0])
    );

    assign pixel_on = |pix;
endmodule

// File: tb/tb_game_clock_countdown.sv
// Directed bench for game_clock_countdown with a 4-cycle second and an offset digit box.

module tb_game_clock_countdown;
    localparam logic [26:0] CPS = 27'd4;
    localparam logic [10:0] XB  = 11'd100;
    localparam logic [9:0]  YB  = 10'd50;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_EXP = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = 16'h0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [10:0] x = 11'd0;
    logic [9:0]  y = 10'd0;
    logic [15:0] digits;
    logic        running, expired, pixel_on;
    logic [1:0]  fsm_state;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] glyph5 [8] = '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00};
    logic [7:0] glyph0_row0 = 8'h3C;

    game_clock_countdown #(.CLKS_PER_SEC(CPS), .X_BOX(XB), .Y_BOX(YB)) dut (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .x(x), .y(y),
        .digits(digits), .running(running), .expired(expired),
        .pixel_on(pixel_on), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_val(input logic [15:0] v);
        load = 1'b1;
        load_value = v;
        step();
        load = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic scan_row(input logic [10:0] x0, input logic [9:0] yy, output logic [7:0] row);
        for (int c = 0; c < 8; c++) begin
            x = x0 + 11'(c);
            y = yy;
            #1;
            row[7-c] = pixel_on;
        end
    endtask

    initial begin
        logic [7:0] row;

        step(2);
        check("reset_digits", 32'(digits), 32'h0000);
        check("reset_running", 32'(running), 32'h0);
        check("reset_expired", 32'(expired), 32'h0);
        check("reset_state", 32'(fsm_state), 32'(S_IDLE));
        rst = 1'b1;
        step();

        start_pulse();
        check("idle_start_zero", 32'(fsm_state), 32'(S_IDLE));

        // Load and count
        load_val(16'h0012);
        check("load_digits", 32'(digits), 32'h0012);
        check("load_running", 32'(running), 32'h0);
        start_pulse();
        check("start_running", 32'(running), 32'h1);
        step(3);
        check("before_tick1", 32'(digits), 32'h0012);
        step();
        check("tick1", 32'(digits), 32'h0011);
        step(4);
        check("tick2", 32'(digits), 32'h0010);
        step(4);
        check("tick3_borrow", 32'(digits), 32'h0009);

        // Borrow chain
        load_val(16'h1000);
        check("load_stops", 32'(running), 32'h0);
        start_pulse();
        step(4);
        check("borrow_1000", 32'(digits), 32'h0959);
        load_val(16'h0100);
        start_pulse();
        step(4);
        check("borrow_0100", 32'(digits), 32'h0059);

        load_val(16'hFA7C);
        check("clamp", 32'(digits), 32'h9959);

        // Expiry
        load_val(16'h0001);
        start_pulse();
        step(3);
        check("pre_expire_digits", 32'(digits), 32'h0001);
        check("pre_expire_pulse", 32'(expired), 32'h0);
        step();
        check("expire_digits", 32'(digits), 32'h0000);
        check("expire_pulse", 32'(expired), 32'h1);
        check("expire_state", 32'(fsm_state), 32'(S_EXP));
        check("expire_running", 32'(running), 32'h0);
        step();
        check("expire_pulse_once", 32'(expired), 32'h0);
        start_pulse();
        check("expired_ignores_start", 32'(fsm_state), 32'(S_EXP));
        check("expired_digits_hold", 32'(digits), 32'h0000);
        load_val(16'h0005);
        check("exit_expired_state", 32'(fsm_state), 32'(S_IDLE));
        check("exit_expired_digits", 32'(digits), 32'h0005);

        // Pause preserves the partial second
        load_val(16'h0010);
        start_pulse();
        step();
        pause = 1'b1;
        step();
        check("pause_state", 32'(fsm_state), 32'(S_PAUSE));
        check("pause_running", 32'(running), 32'h0);
        step(10);
        check("pause_frozen", 32'(digits), 32'h0010);
        pause = 1'b0;
        start_pulse();
        check("resume_running", 32'(running), 32'h1);
        step();
        check("resume_plus1", 32'(digits), 32'h0010);
        step();
        check("resume_plus2", 32'(digits), 32'h0009);
        start = 1'b1;
        pause = 1'b1;
        step();
        check("run_start_pause", 32'(fsm_state), 32'(S_PAUSE));
        step();
        check("paused_start_pause", 32'(fsm_state), 32'(S_PAUSE));
        start = 1'b0;
        pause = 1'b0;

        // Asynchronous reset between edges
        load_val(16'h0055);
        start_pulse();
        step(2);
        #2;
        rst = 1'b0;
        #1;
        check("async_digits", 32'(digits), 32'h0000);
        check("async_running", 32'(running), 32'h0);
        check("async_expired", 32'(expired), 32'h0);
        check("async_state", 32'(fsm_state), 32'(S_IDLE));
        step();
        rst = 1'b1;
        step();

        // Display: S1=5 glyph, S0=0 glyph, colon gap dark
        load_val(16'h0050);
        for (int r = 0; r < 8; r++) begin
            scan_row(XB + 11'd24, YB + 10'(r), row);
            check($sformatf("s1_glyph5_row%0d", r), 32'(row), 32'(glyph5[r]));
        end
        scan_row(XB + 11'd32, YB, row);
        check("s0_glyph0_row0", 32'(row), 32'(glyph0_row0));
        scan_row(XB + 11'd16, YB + 10'd1, row);
        check("colon_gap_dark", 32'(row), 32'h00);
        scan_row(XB + 11'd24, YB + 10'd8, row);
        check("below_box_dark", 32'(row), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
